mips_multicycle_ctrl: RTL and testbench

Multicycle MIPS control unit: a Moore FSM sequencing fetch, decode, execute, memory and writeback, with the ALU function decode folded in and widened to the full 6-bit funct field.
Sits between the instruction register (op, funct) and the shared-ALU/single-memory multicycle datapath.
Replaces the combinational main/ALU decoder pair when the core moves from single-cycle to multicycle.
Adds illegal-instruction detection and optional addi/j/bne support.

---
 rtl/mips_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore-style control FSM for a multicycle MIPS datapath with one shared ALU
//   and one memory. It sequences fetch, decode, execute, memory and writeback,
//   and it also performs the ALU function decode over the full 6-bit funct field.
//   Unsupported opcodes and functs raise a one-cycle illegal_op pulse, and the
//   FSM then returns to FETCH without a register or memory write.
//
// Parameters
//   ENABLE_ADDI / ENABLE_J / ENABLE_BNE : decode addi / j / bne. When a flag is
//                                         0, that opcode is treated as illegal.
//   ALUCTRL_W                           : ALUControl width. The 3-bit codes are
//                                         zero-extended to this width.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-high reset
//   op, funct           instruction fields held in the instruction register
//   zero                ALU zero flag, used to qualify branches
//   IorD .. PCSrc       datapath multiplexer selects and write strobes
//   PCEn                PC load: PCWrite | (Branch & zero) | (BranchN & ~zero)
//   ALUControl          ALU operation code
//   illegal_op          pulses high in the cycle that rejects an op or funct
//   state_o             current state, for debug
module mips_multicycle_ctrl #(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1,
    parameter bit ENABLE_BNE  = 1'b0,
    parameter int ALUCTRL_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSrc,
    output logic                 PCEn,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal_op,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        BNE    = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_FUNCT
    } alu_mode_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_AD  = 3'b010;
    localparam logic [2:0] ALU_BAD = 3'b011;
    localparam logic [2:0] ALU_SB  = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t    state;
    state_t    next_state;
    alu_mode_t alu_mode;

    logic [2:0] funct_code;
    logic       funct_legal;
    logic [2:0] alu_code;

    logic       pc_write;
    logic       branch;
    logic       branch_n;
    logic       iord_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] pc_src_s;
    logic       illegal_s;

    // NOTE: the state register uses a synchronous reset and non-blocking
    // assignments, so every reader sees the value from before the edge.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // R-type function decode. Any funct not listed here is rejected in EXEC.
    always_comb begin
        funct_code  = ALU_BAD;
        funct_legal = 1'b1;
        case (funct)
            6'b100000: funct_code = ALU_AD;
            6'b100010: funct_code = ALU_SB;
            6'b100100: funct_code = ALU_AND;
            6'b100101: funct_code = ALU_OR;
            6'b101010: funct_code = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the case statement. This
    // prevents latches, and it makes unused encodings (13-15) fall back to
    // FETCH with every enable at 0.
    always_comb begin
        next_state   = FETCH;
        pc_write     = 1'b0;
        branch       = 1'b0;
        branch_n     = 1'b0;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        pc_src_s     = 2'b00;
        alu_mode     = ALU_ADD;
        illegal_s    = 1'b0;

        case (state)
            FETCH: begin
                alu_src_b_s = 2'b01;
                ir_write_s  = 1'b1;
                pc_write    = 1'b1;
                next_state  = DECODE;
            end
            DECODE: begin
                // Compute the branch target early. The ALU is otherwise idle here.
                alu_src_b_s = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC;
                    OP_BEQ:       next_state = BEQ;
                    OP_BNE: begin
                        if (ENABLE_BNE) next_state = BNE;
                        else            illegal_s  = 1'b1;
                    end
                    OP_ADDI: begin
                        if (ENABLE_ADDI) next_state = ADDIEX;
                        else             illegal_s  = 1'b1;
                    end
                    OP_J: begin
                        if (ENABLE_J) next_state = JUMP;
                        else          illegal_s  = 1'b1;
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                next_state  = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord_s     = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
            end
            MEMWR: begin
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
            end
            EXEC: begin
                alu_src_a_s = 1'b1;
                alu_mode    = ALU_FUNCT;
                // A bad funct skips ALUWB, so the register file is never written.
                if (funct_legal) next_state = ALUWB;
                else             illegal_s  = 1'b1;
            end
            ALUWB: begin
                reg_dst_s   = 1'b1;
                reg_write_s = 1'b1;
            end
            BEQ: begin
                alu_src_a_s = 1'b1;
                alu_mode    = ALU_SUB;
                pc_src_s    = 2'b01;
                branch      = 1'b1;
            end
            BNE: begin
                alu_src_a_s = 1'b1;
                alu_mode    = ALU_SUB;
                pc_src_s    = 2'b01;
                branch_n    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                next_state  = ADDIWB;
            end
            ADDIWB: begin
                reg_write_s = 1'b1;
            end
            JUMP: begin
                pc_src_s = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_code = ALU_AD;
        case (alu_mode)
            ALU_SUB:   alu_code = ALU_SB;
            ALU_FUNCT: alu_code = funct_code;
            default:   alu_code = ALU_AD;
        endcase
    end

    // While reset is high the outputs show FETCH values, with every write
    // strobe held low. An aborted instruction therefore cannot write
    // anything during the reset cycle.
    assign IorD       = reset ? 1'b0  : iord_s;
    assign MemWrite   = ~reset & mem_write_s;
    assign IRWrite    = ~reset & ir_write_s;
    assign RegDst     = reset ? 1'b0  : reg_dst_s;
    assign MemtoReg   = reset ? 1'b0  : mem_to_reg_s;
    assign RegWrite   = ~reset & reg_write_s;
    assign ALUSrcA    = reset ? 1'b0  : alu_src_a_s;
    assign ALUSrcB    = reset ? 2'b01 : alu_src_b_s;
    assign PCSrc      = reset ? 2'b00 : pc_src_s;
    assign PCEn       = ~reset & (pc_write | (branch & zero) | (branch_n & ~zero));
    assign ALUControl = ALUCTRL_W'(reset ? ALU_AD : alu_code);
    assign illegal_op = ~reset & illegal_s;
    assign state_o    = reset ? FETCH : state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl.
// dut_a uses the default parameters: addi and j are enabled, bne is disabled.
// dut_b enables bne, disables j, and uses a 4-bit ALUControl.
// Both instances share the same stimulus. A reset re-aligns them before
// dut_b is checked on its own.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       iord_a, memwrite_a, irwrite_a, regdst_a, memtoreg_a, regwrite_a, alusrca_a, pcen_a, illegal_a;
    logic [1:0] alusrcb_a, pcsrc_a;
    logic [2:0] aluc_a;
    logic [3:0] state_a;

    logic       iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b, pcen_b, illegal_b;
    logic [1:0] alusrcb_b, pcsrc_b;
    logic [3:0] aluc_b;
    logic [3:0] state_b;

    mips_multicycle_ctrl dut_a (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .IorD(iord_a), .MemWrite(memwrite_a), .IRWrite(irwrite_a), .RegDst(regdst_a),
        .MemtoReg(memtoreg_a), .RegWrite(regwrite_a), .ALUSrcA(alusrca_a), .ALUSrcB(alusrcb_a),
        .PCSrc(pcsrc_a), .PCEn(pcen_a), .ALUControl(aluc_a), .illegal_op(illegal_a), .state_o(state_a)
    );

    mips_multicycle_ctrl #(
        .ENABLE_ADDI(1'b1), .ENABLE_J(1'b0), .ENABLE_BNE(1'b1), .ALUCTRL_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .IorD(iord_b), .MemWrite(memwrite_b), .IRWrite(irwrite_b), .RegDst(regdst_b),
        .MemtoReg(memtoreg_b), .RegWrite(regwrite_b), .ALUSrcA(alusrca_b), .ALUSrcB(alusrcb_b),
        .PCSrc(pcsrc_b), .PCEn(pcen_b), .ALUControl(aluc_b), .illegal_op(illegal_b), .state_o(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitors select the instance under test.
    logic       sel_b;
    logic [3:0] m_state, m_aluc;
    logic [1:0] m_pcsrc;
    logic       m_regwrite, m_memwrite, m_iord, m_memtoreg, m_regdst, m_pcen, m_ill, m_irwrite;

    assign m_state    = sel_b ? state_b    : state_a;
    assign m_aluc     = sel_b ? aluc_b     : {1'b0, aluc_a};
    assign m_pcsrc    = sel_b ? pcsrc_b    : pcsrc_a;
    assign m_regwrite = sel_b ? regwrite_b : regwrite_a;
    assign m_memwrite = sel_b ? memwrite_b : memwrite_a;
    assign m_iord     = sel_b ? iord_b     : iord_a;
    assign m_memtoreg = sel_b ? memtoreg_b : memtoreg_a;
    assign m_regdst   = sel_b ? regdst_b   : regdst_a;
    assign m_pcen     = sel_b ? pcen_b     : pcen_a;
    assign m_ill      = sel_b ? illegal_b  : illegal_a;
    assign m_irwrite  = sel_b ? irwrite_b  : irwrite_a;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-cycle history of the last instruction. Bit i holds the value in cycle i.
    logic [7:0] rw_hist, mw_hist, iord_hist, m2r_hist, regdst_hist, pcen_hist, ill_hist;
    logic [3:0] aluc_hist  [8];
    logic [1:0] pcsrc_hist [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH. It checks the state sequence, with the
    // first state in the low nibble of seq, and records the outputs of each cycle.
    task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [31:0] seq, input int len);
        op = o; funct = f; zero = z;
        rw_hist = '0; mw_hist = '0; iord_hist = '0; m2r_hist = '0;
        regdst_hist = '0; pcen_hist = '0; ill_hist = '0;
        #1;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_state%0d", tag, i), {28'd0, m_state}, {28'd0, seq[4*i +: 4]});
            rw_hist[i]     = m_regwrite;
            mw_hist[i]     = m_memwrite;
            iord_hist[i]   = m_iord;
            m2r_hist[i]    = m_memtoreg;
            regdst_hist[i] = m_regdst;
            pcen_hist[i]   = m_pcen;
            ill_hist[i]    = m_ill;
            aluc_hist[i]   = m_aluc;
            pcsrc_hist[i]  = m_pcsrc;
            step();
        end
    endtask

    logic [5:0] rfun [5];
    logic [3:0] rexp [5];

    initial begin
        sel_b = 1'b0;
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_state",   m_state,   4'd0);
            check("rst_irwrite", m_irwrite, 1'b0);
            check("rst_pcen",    m_pcen,    1'b0);
        end
        reset = 1'b0;
        #1;
        check("post_rst_state",   m_state,   4'd0);
        check("post_rst_irwrite", m_irwrite, 1'b1);
        check("post_rst_pcen",    m_pcen,    1'b1);

        // lw: five cycles. Memory read in state 3, register write in state 4.
        run("lw", 6'b100011, 6'b000000, 1'b0, 32'h43210, 5);
        check("lw_regwrite", rw_hist[4:0],  5'b10000);
        check("lw_memtoreg", m2r_hist[4:0], 5'b10000);
        check("lw_iord",     iord_hist[4:0], 5'b01000);
        check("lw_memwrite", mw_hist[4:0],  5'b00000);

        // R-type instructions. Each funct maps to its ALU code in EXEC.
        rfun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        rexp = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111};
        for (int k = 0; k < 5; k++) begin
            run($sformatf("rtype%0d", k), 6'b000000, rfun[k], 1'b0, 32'h7610, 4);
            check($sformatf("rtype%0d_aluc", k),     aluc_hist[2],     rexp[k]);
            check($sformatf("rtype%0d_regwrite", k), rw_hist[3:0],     4'b1000);
            check($sformatf("rtype%0d_regdst", k),   regdst_hist[3],   1'b1);
        end

        // beq taken, then not taken.
        run("beq_t", 6'b000100, 6'b000000, 1'b1, 32'h810, 3);
        check("beq_t_pcen",  pcen_hist[2],  1'b1);
        check("beq_t_pcsrc", pcsrc_hist[2], 2'b01);
        check("beq_t_aluc",  aluc_hist[2],  4'b0110);
        run("beq_n", 6'b000100, 6'b000000, 1'b0, 32'h810, 3);
        check("beq_n_pcen",  pcen_hist[2],  1'b0);

        // sw: four cycles, memory write only in MEMWR.
        run("sw", 6'b101011, 6'b000000, 1'b0, 32'h5210, 4);
        check("sw_memwrite", mw_hist[3:0], 4'b1000);
        check("sw_regwrite", rw_hist[3:0], 4'b0000);

        // addi: four cycles. It writes rt with the ALU result.
        run("addi", 6'b001000, 6'b000000, 1'b0, 32'hA910, 4);
        check("addi_regwrite", rw_hist[3:0],    4'b1000);
        check("addi_regdst",   regdst_hist[3],  1'b0);
        check("addi_aluc",     aluc_hist[2],    4'b0010);

        // Illegal opcode: two cycles, with the pulse only in DECODE.
        run("ill_op", 6'b111111, 6'b000000, 1'b0, 32'h10, 2);
        check("ill_op_pulse",    ill_hist[1:0], 2'b10);
        check("ill_op_regwrite", rw_hist[1:0],  2'b00);
        check("ill_op_memwrite", mw_hist[1:0],  2'b00);

        // Illegal funct: rejected in EXEC, with no writeback afterwards.
        run("ill_fn", 6'b000000, 6'b000111, 1'b0, 32'h610, 3);
        check("ill_fn_pulse",    ill_hist[2:0], 3'b100);
        check("ill_fn_aluc",     aluc_hist[2],  4'b0011);
        check("ill_fn_regwrite", rw_hist[2:0],  3'b000);
        check("ill_fn_memwrite", mw_hist[2:0],  3'b000);

        // From here on dut_b drifts out of step with dut_a until the next reset.
        run("j_a", 6'b000010, 6'b000000, 1'b0, 32'hB10, 3);
        check("j_a_pcen",  pcen_hist[2],  1'b1);
        check("j_a_pcsrc", pcsrc_hist[2], 2'b10);
        check("j_a_ill",   ill_hist[2:0], 3'b000);

        run("bne_a", 6'b000101, 6'b000000, 1'b0, 32'h10, 2);
        check("bne_a_ill", ill_hist[1:0], 2'b10);

        // Reset asserted in MEMWR aborts the store.
        op = 6'b101011;
        #1;
        check("abort_fetch", m_state, 4'd0);
        step(); step(); step();
        check("abort_memwr_state", m_state,    4'd5);
        check("abort_memwr_write", m_memwrite, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_rst_memwrite", m_memwrite, 1'b0);
        check("abort_rst_regwrite", m_regwrite, 1'b0);
        check("abort_rst_pcen",     m_pcen,     1'b0);
        check("abort_rst_state",    m_state,    4'd0);
        step();
        reset = 1'b0;
        #1;
        check("abort_next_state",   m_state,   4'd0);
        check("abort_next_irwrite", m_irwrite, 1'b1);
        check("abort_b_state",      state_b,   4'd0);

        // dut_b: bne enabled, so PCEn is the inverse of the beq case. j is disabled.
        sel_b = 1'b1;
        run("bne_t", 6'b000101, 6'b000000, 1'b0, 32'hC10, 3);
        check("bne_t_pcen",  pcen_hist[2],  1'b1);
        check("bne_t_pcsrc", pcsrc_hist[2], 2'b01);
        check("bne_t_aluc",  aluc_hist[2],  4'b0110);
        run("bne_n", 6'b000101, 6'b000000, 1'b1, 32'hC10, 3);
        check("bne_n_pcen",  pcen_hist[2],  1'b0);
        run("j_b", 6'b000010, 6'b000000, 1'b0, 32'h10, 2);
        check("j_b_ill",  ill_hist[1:0],  2'b10);
        check("j_b_pcen", pcen_hist[1:0], 2'b01);
        check("final_fetch", m_state, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
